pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Parametrised supervisor for NUM_PLLS MMCM/PLL instances in the clock generation tree. It drives each PLL's RST, filters each PLL's LOCKED signal, and gates the matching BUFGCE CE. It sequences per-domain synchronous reset release and retries PLLs that fail to lock. It also recovers automatically from loss of lock and latches a sticky fault after repeated failures.

Parameters:
NUM_PLLS, 3, number of supervised PLL/MMCM channels
RST_PULSE, 16, cycles pll_rst is held high per reset attempt (≥1)
LOCK_FILTER, 64, consecutive synced-locked cycles required before a channel is considered locked (≥1)
LOCK_TIMEOUT, 131072, cycles in WAIT_LOCK before the attempt is abandoned
MAX_RETRIES, 4, consecutive failed attempts before a channel enters FAULT
RELEASE_DELAY, 8, cycles between clk_en rising and domain_rst_n release
ORDERED, 1, 1 = domain i may release only after domain i-1 is released; 0 = channels independent
CNT_W, 8, width of each relock counter

Ports:
clk  input  1  free-running supervisor clock (undivided board oscillator, not PLL-derived)
rst_n  input  1  synchronous active-low reset
pll_locked  input  NUM_PLLS  raw LOCKED from each PLL, asynchronous to clk
pll_rst  output  NUM_PLLS  RST to each PLL, active high
clk_en  output  NUM_PLLS  CE for each channel's output BUFGCE/BUFHCE
domain_rst_n  output  NUM_PLLS  active-low reset for logic clocked from channel i
all_ready  output  1  high when every domain_rst_n bit is high
fault  output  NUM_PLLS  sticky per-channel fault flag
fault_clear  input  NUM_PLLS  one-cycle pulse; restarts a FAULTed channel
relock_count  output  NUM_PLLS*CNT_W  per-channel count of lock losses while in RUN; saturating; channel i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset: when rst_n is low at a clk edge, every channel goes to state PLL_RST with all counters and retry counts cleared. Output values: pll_rst all 1, clk_en 0, domain_rst_n 0, fault 0, relock_count 0, all_ready 0.
- Lock input: each pll_locked bit passes through a 2-FF synchronizer, giving locked_s with 2 cycles of latency. The FSM uses only locked_s.
- Per-channel FSM:
  - PLL_RST: pll_rst=1. Hold for exactly RST_PULSE cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0; filter counter and timeout counter both run.
    - Filter counter: increments while locked_s=1 and clears to 0 when locked_s=0.
    - If the filter counter reaches LOCK_FILTER: go to RUN_WAIT and clear the retry count.
    - Else if the timeout counter reaches LOCK_TIMEOUT: retry count +1. If the new retry count equals MAX_RETRIES, go to FAULT; otherwise go to PLL_RST.
    - If lock and timeout occur in the same cycle, lock wins.
  - RUN_WAIT: clk_en=1, domain_rst_n=0, release counter runs.
    - Go to RUN when the counter has reached RELEASE_DELAY and, if ORDERED=1, domain_rst_n[i-1]=1. Channel 0 is never gated by ordering.
  - RUN: clk_en=1, domain_rst_n=1.
  - Lock loss in RUN_WAIT or RUN: if locked_s=0 for any single cycle, then on that same edge clk_en←0, domain_rst_n←0, state←PLL_RST, and relock_count +1 (saturating at 2^CNT_W−1). The counter increments only if the channel was in RUN.
  - Ordered cascade: with ORDERED=1, any channel j>i whose domain_rst_n is 1 drops to RUN_WAIT on the cycle after domain_rst_n[i] falls. It keeps clk_en=1 and restarts its release counter.
  - FAULT: pll_rst=1, clk_en=0, domain_rst_n=0, fault[i]=1.
    - fault_clear[i]=1 → fault←0, retry count cleared, go to PLL_RST.
    - fault_clear in any other state is ignored.
- all_ready is registered: it equals the AND of domain_rst_n, one cycle late.
- rst_n low mid-sequence overrides all of the above on that edge.

Test Plan:
Bench parameters: NUM_PLLS=3, RST_PULSE=3, LOCK_FILTER=4, LOCK_TIMEOUT=32, MAX_RETRIES=2, RELEASE_DELAY=2, ORDERED=1.
1. Normal bring-up: release rst_n with pll_locked=3'b111 → pll_rst high for 3 cycles, then clk_en=111 at +2 sync +4 filter. domain_rst_n releases in order 001→011→111, then all_ready=1 one cycle later.
2. Glitch: drop pll_locked[1] for one cycle while in RUN → clk_en[1]=0, domain_rst_n=3'b001, relock_count[1]=1. Channel 2 restarts RELEASE_DELAY after channel 1 re-releases.
3. Filter reset: in WAIT_LOCK, pattern locked 1,1,1,0,1,1,1,1 → RUN_WAIT entered only after the final 4 consecutive 1s.
4. Timeout and fault: hold pll_locked[2]=0 → two 32-cycle attempts, then fault=3'b100 and pll_rst[2] stuck at 1. Pulse fault_clear[2] → fault cleared and a new 3-cycle pll_rst pulse.
5. Saturation: with CNT_W=2, cause 5 lock losses on channel 0 → relock_count[0] stays at 3.
6. Reset mid-operation: assert rst_n=0 for 1 cycle while in RUN → next cycle outputs pll_rst=111, clk_en=000, domain_rst_n=000, fault=000, relock_count=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Per-channel PLL/MMCM supervisor: reset pulsing, filtered lock detection with
// timeout/retry/fault, BUFGCE enable gating and ordered domain reset release.
module pll_lock_supervisor #(
  parameter int NUM_PLLS      = 3,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_FILTER   = 64,
  parameter int LOCK_TIMEOUT  = 131072,
  parameter int MAX_RETRIES   = 4,
  parameter int RELEASE_DELAY = 8,
  parameter int ORDERED       = 1,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_PLLS-1:0]       pll_locked,
  output logic [NUM_PLLS-1:0]       pll_rst,
  output logic [NUM_PLLS-1:0]       clk_en,
  output logic [NUM_PLLS-1:0]       domain_rst_n,
  output logic                      all_ready,
  output logic [NUM_PLLS-1:0]       fault,
  input  logic [NUM_PLLS-1:0]       fault_clear,
  output logic [NUM_PLLS*CNT_W-1:0] relock_count
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int TMR_W  = $clog2(max3(RST_PULSE, LOCK_TIMEOUT, RELEASE_DELAY) + 1);
  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int RTY_W  = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RUN_WAIT  = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [NUM_PLLS-1:0] sync1_q;
  logic [NUM_PLLS-1:0] sync2_q;

  state_t            state_q  [NUM_PLLS];
  state_t            state_d  [NUM_PLLS];
  logic [TMR_W-1:0]  tmr_q    [NUM_PLLS];
  logic [TMR_W-1:0]  tmr_d    [NUM_PLLS];
  logic [FILT_W-1:0] filt_q   [NUM_PLLS];
  logic [FILT_W-1:0] filt_d   [NUM_PLLS];
  logic [RTY_W-1:0]  rty_q    [NUM_PLLS];
  logic [RTY_W-1:0]  rty_d    [NUM_PLLS];
  logic [CNT_W-1:0]  relock_q [NUM_PLLS];
  logic [CNT_W-1:0]  relock_d [NUM_PLLS];

  logic [NUM_PLLS-1:0] pll_rst_q, pll_rst_d;
  logic [NUM_PLLS-1:0] clk_en_q, clk_en_d;
  logic [NUM_PLLS-1:0] dom_q, dom_d;
  logic [NUM_PLLS-1:0] fault_q, fault_d;
  logic                all_ready_q;
  logic [NUM_PLLS-1:0] pred_rel;
  logic                lower_ok;

  // Two-flop synchronizer for the asynchronous LOCKED inputs; carries no state worth resetting.
  always_ff @(posedge clk) begin
    sync1_q <= pll_locked;
    sync2_q <= sync1_q;
  end

  // Bit i holds the released state of channel i-1; channel 0 always sees 1.
  assign pred_rel = (dom_q << 1) | NUM_PLLS'(1);

  always_comb begin
    lower_ok = 1'b1;
    for (int i = 0; i < NUM_PLLS; i++) begin
      state_d[i]  = state_q[i];
      tmr_d[i]    = tmr_q[i];
      filt_d[i]   = filt_q[i];
      rty_d[i]    = rty_q[i];
      relock_d[i] = relock_q[i];
      case (state_q[i])
        S_PLL_RST: begin
          if (int'(tmr_q[i]) >= RST_PULSE - 1) begin
            state_d[i] = S_WAIT_LOCK;
            tmr_d[i]   = '0;
            filt_d[i]  = '0;
          end else begin
            tmr_d[i] = tmr_q[i] + TMR_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (sync2_q[i] && int'(filt_q[i]) >= LOCK_FILTER - 1) begin
            state_d[i] = S_RUN_WAIT;
            tmr_d[i]   = '0;
            rty_d[i]   = '0;
          end else if (int'(tmr_q[i]) >= LOCK_TIMEOUT - 1) begin
            tmr_d[i]   = '0;
            rty_d[i]   = rty_q[i] + RTY_W'(1);
            state_d[i] = (int'(rty_q[i]) >= MAX_RETRIES - 1) ? S_FAULT : S_PLL_RST;
          end else begin
            tmr_d[i]  = tmr_q[i] + TMR_W'(1);
            filt_d[i] = sync2_q[i] ? filt_q[i] + FILT_W'(1) : '0;
          end
        end
        S_RUN_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_PLL_RST;
            tmr_d[i]   = '0;
          end else if (int'(tmr_q[i]) + 1 >= RELEASE_DELAY) begin
            if (ORDERED == 0 || pred_rel[i]) state_d[i] = S_RUN;
          end else begin
            tmr_d[i] = tmr_q[i] + TMR_W'(1);
          end
        end
        S_RUN: begin
          if (!sync2_q[i]) begin
            state_d[i]  = S_PLL_RST;
            tmr_d[i]    = '0;
            relock_d[i] = sat_inc(relock_q[i]);
          end else if (ORDERED != 0 && !lower_ok) begin
            // A lower domain went back into reset: hold clocks but re-sequence release.
            state_d[i] = S_RUN_WAIT;
            tmr_d[i]   = '0;
          end
        end
        S_FAULT: begin
          if (fault_clear[i]) begin
            state_d[i] = S_PLL_RST;
            tmr_d[i]   = '0;
            rty_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = S_PLL_RST;
          tmr_d[i]   = '0;
        end
      endcase
      pll_rst_d[i] = (state_d[i] == S_PLL_RST) || (state_d[i] == S_FAULT);
      clk_en_d[i]  = (state_d[i] == S_RUN_WAIT) || (state_d[i] == S_RUN);
      dom_d[i]     = (state_d[i] == S_RUN);
      fault_d[i]   = (state_d[i] == S_FAULT);
      lower_ok     = lower_ok & dom_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PLLS; i++) begin
        state_q[i]  <= S_PLL_RST;
        tmr_q[i]    <= '0;
        filt_q[i]   <= '0;
        rty_q[i]    <= '0;
        relock_q[i] <= '0;
      end
      pll_rst_q   <= '1;
      clk_en_q    <= '0;
      dom_q       <= '0;
      fault_q     <= '0;
      all_ready_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PLLS; i++) begin
        state_q[i]  <= state_d[i];
        tmr_q[i]    <= tmr_d[i];
        filt_q[i]   <= filt_d[i];
        rty_q[i]    <= rty_d[i];
        relock_q[i] <= relock_d[i];
      end
      pll_rst_q   <= pll_rst_d;
      clk_en_q    <= clk_en_d;
      dom_q       <= dom_d;
      fault_q     <= fault_d;
      all_ready_q <= &dom_q;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign clk_en       = clk_en_q;
  assign domain_rst_n = dom_q;
  assign fault        = fault_q;
  assign all_ready    = all_ready_q;

  for (genvar g = 0; g < NUM_PLLS; g++) begin : g_relock
    assign relock_count[g*CNT_W +: CNT_W] = relock_q[g];
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock/fault_clear/reset
// traffic, all checked every cycle against a phase-level behavioural model.
module tb_pll_lock_supervisor;

  localparam int NP   = 3;
  localparam int RSTP = 3;
  localparam int LF   = 4;
  localparam int LT   = 32;
  localparam int MR   = 2;
  localparam int RD   = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_REL  = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_FLT  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    pll_locked;
  logic [NP-1:0]    fault_clear;
  logic [NP-1:0]    pll_rst;
  logic [NP-1:0]    clk_en;
  logic [NP-1:0]    domain_rst_n;
  logic             all_ready;
  logic [NP-1:0]    fault;
  logic [NP*CW-1:0] relock_count;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .NUM_PLLS(NP), .RST_PULSE(RSTP), .LOCK_FILTER(LF), .LOCK_TIMEOUT(LT),
    .MAX_RETRIES(MR), .RELEASE_DELAY(RD), .ORDERED(1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .clk_en(clk_en), .domain_rst_n(domain_rst_n), .all_ready(all_ready),
    .fault(fault), .fault_clear(fault_clear), .relock_count(relock_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: each channel is a phase plus the number of edges spent in it.
  int ph [NP];
  int age [NP];
  int streak [NP];
  int fails [NP];
  int losses [NP];
  bit s1 [NP];
  bit s2 [NP];
  bit exp_ready;

  task automatic model_step();
    bit rel_old [NP];
    bit ls;
    bit all_lower;
    for (int c = 0; c < NP; c++) rel_old[c] = (ph[c] == PH_RUN);
    if (!rst_n) begin
      for (int c = 0; c < NP; c++) begin
        ph[c] = PH_RST; age[c] = 0; streak[c] = 0; fails[c] = 0; losses[c] = 0;
      end
      exp_ready = 1'b0;
    end else begin
      exp_ready = rel_old[0] && rel_old[1] && rel_old[2];
      all_lower = 1'b1;
      for (int c = 0; c < NP; c++) begin
        ls = s2[c];
        case (ph[c])
          PH_RST: begin
            age[c]++;
            if (age[c] == RSTP) begin ph[c] = PH_WAIT; age[c] = 0; streak[c] = 0; end
          end
          PH_WAIT: begin
            age[c]++;
            streak[c] = ls ? streak[c] + 1 : 0;
            if (streak[c] == LF) begin
              ph[c] = PH_REL; age[c] = 0; fails[c] = 0;
            end else if (age[c] == LT) begin
              fails[c]++;
              ph[c] = (fails[c] == MR) ? PH_FLT : PH_RST;
              age[c] = 0;
            end
          end
          PH_REL: begin
            if (!ls) begin
              ph[c] = PH_RST; age[c] = 0;
            end else begin
              age[c]++;
              if (age[c] >= RD && (c == 0 || rel_old[c-1])) ph[c] = PH_RUN;
            end
          end
          PH_RUN: begin
            if (!ls) begin
              ph[c] = PH_RST; age[c] = 0;
              if (losses[c] < CMAX) losses[c]++;
            end else if (!all_lower) begin
              ph[c] = PH_REL; age[c] = 0;
            end
          end
          default: begin
            if (fault_clear[c]) begin ph[c] = PH_RST; age[c] = 0; fails[c] = 0; end
          end
        endcase
        all_lower = all_lower && rel_old[c];
      end
    end
    for (int c = 0; c < NP; c++) begin
      s2[c] = s1[c];
      s1[c] = pll_locked[c];
    end
  endtask

  function automatic logic [NP-1:0] vec_of(input int p1, input int p2);
    logic [NP-1:0] v;
    for (int c = 0; c < NP; c++) v[c] = (ph[c] == p1) || (ph[c] == p2);
    return v;
  endfunction

  task automatic compare_all();
    logic [NP*CW-1:0] rc;
    for (int c = 0; c < NP; c++) rc[c*CW +: CW] = CW'(losses[c]);
    chk("pll_rst", 32'(pll_rst), 32'(vec_of(PH_RST, PH_FLT)));
    chk("clk_en", 32'(clk_en), 32'(vec_of(PH_REL, PH_RUN)));
    chk("domain_rst_n", 32'(domain_rst_n), 32'(vec_of(PH_RUN, PH_RUN)));
    chk("fault", 32'(fault), 32'(vec_of(PH_FLT, PH_FLT)));
    chk("all_ready", 32'(all_ready), 32'(exp_ready));
    chk("relock_count", 32'(relock_count), 32'(rc));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    for (int c = 0; c < NP; c++) begin
      ph[c] = PH_RST; age[c] = 0; streak[c] = 0; fails[c] = 0; losses[c] = 0;
      s1[c] = 1'b0; s2[c] = 1'b0;
    end
    exp_ready   = 1'b0;
    rst_n       = 1'b0;
    pll_locked  = 3'b111;
    fault_clear = 3'b000;
    run(5);
    chk("reset_pll_rst", 32'(pll_rst), 32'h7);
    chk("reset_clk_en", 32'(clk_en), 32'h0);
    chk("reset_dom", 32'(domain_rst_n), 32'h0);
    chk("reset_relock", 32'(relock_count), 32'h0);

    // Normal bring-up with timing pinned to edge numbers after reset release.
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      chk("bringup_pll_rst", 32'(pll_rst), (e <= 2) ? 32'h7 : 32'h0);
      chk("bringup_clk_en", 32'(clk_en), (e >= 7) ? 32'h7 : 32'h0);
      chk("bringup_dom", 32'(domain_rst_n),
          (e >= 11) ? 32'h7 : (e == 10) ? 32'h3 : (e == 9) ? 32'h1 : 32'h0);
      chk("bringup_ready", 32'(all_ready), (e >= 12) ? 32'h1 : 32'h0);
    end
    run(3);

    // One-cycle glitch on channel 1 while running.
    pll_locked = 3'b101;
    cycle();
    pll_locked = 3'b111;
    run(3);
    chk("glitch_dom", 32'(domain_rst_n), 32'h1);
    chk("glitch_clk_en", 32'(clk_en), 32'h5);
    run(26);
    chk("glitch_relock1", 32'(relock_count[3:2]), 32'h1);
    chk("glitch_recovered", 32'(domain_rst_n), 32'h7);

    // Filter restart: drive channel 0 into WAIT_LOCK, then 1,1,1,0,1,1,1,1.
    pll_locked = 3'b110;
    run(8);
    for (int k = 0; k < 8; k++) begin
      pll_locked = {2'b11, (k != 3)};
      cycle();
    end
    cycle();
    chk("filter_not_yet", 32'(clk_en[0]), 32'h0);
    cycle();
    chk("filter_locked", 32'(clk_en[0]), 32'h1);
    run(20);

    // Timeout and fault on channel 2, then ignored and honoured fault_clear.
    pll_locked = 3'b011;
    run(80);
    chk("fault_set", 32'(fault), 32'h4);
    chk("fault_pll_rst2", 32'(pll_rst[2]), 32'h1);
    fault_clear = 3'b011;
    cycle();
    chk("fault_clear_ignored", 32'(fault), 32'h4);
    fault_clear = 3'b100;
    cycle();
    fault_clear = 3'b000;
    chk("fault_cleared", 32'(fault), 32'h0);
    chk("fault_new_pulse", 32'(pll_rst[2]), 32'h1);
    pll_locked = 3'b111;
    run(30);

    // Five lock losses on channel 0 saturate its two-bit counter.
    for (int n = 0; n < 5; n++) begin
      pll_locked = 3'b110;
      cycle();
      pll_locked = 3'b111;
      run(20);
    end
    chk("relock0_saturated", 32'(relock_count[1:0]), 32'h3);

    // One-cycle reset while everything runs.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("midrst_pll_rst", 32'(pll_rst), 32'h7);
    chk("midrst_clk_en", 32'(clk_en), 32'h0);
    chk("midrst_dom", 32'(domain_rst_n), 32'h0);
    chk("midrst_fault", 32'(fault), 32'h0);
    chk("midrst_relock", 32'(relock_count), 32'h0);
    run(20);

    // Random lock traffic, sparse fault_clear pulses and occasional resets.
    for (int k = 0; k < 500; k++) begin
      for (int c = 0; c < NP; c++)
        if ($urandom_range(0, 15) == 0) pll_locked[c] = ~pll_locked[c];
      fault_clear = 3'b000;
      for (int c = 0; c < NP; c++)
        if ($urandom_range(0, 19) == 0) fault_clear[c] = 1'b1;
      rst_n = ($urandom_range(0, 149) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
